// File: rtl/onehot_mux_pkg.sv
// Shared constants and helpers for the one-hot arbitrated multiplexer.
// Arbitration-mode encodings and a one-hot to index converter.
package onehot_mux_pkg;

    localparam int MODE_FIXED   = 0;
    localparam int MODE_RR      = 1;
    localparam int ONEHOT_MAX_W = 64;

    // ORing the indices of set bits gives the index directly for a one-hot vector.
    function automatic logic [31:0] onehot_index(input logic [ONEHOT_MAX_W-1:0] vec);
        logic [31:0] idx;
        idx = 32'd0;
        for (int k = 0; k < ONEHOT_MAX_W; k++) begin
            idx = vec[k] ? (idx | 32'(k)) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_arb_mux_chk.sv
// Property checker for onehot_arb_mux: the grant is never more than one-hot.
module onehot_arb_mux_chk #(
    parameter int NUM_CH = 4
) (
    input logic              clk,
    input logic [NUM_CH-1:0] gnt
);

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: rtl/onehot_rr_arb.sv
// One-hot arbiter: fixed lowest-index priority, or round-robin from a pointer
// implemented as a masked pass (channels >= ptr) falling back to an unmasked pass.
module onehot_rr_arb
    import onehot_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MODE   = MODE_RR,
    localparam int PTR_W = $clog2(NUM_CH)
) (
    input  logic              i_en,
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt
);

    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_req_hi;
    logic [NUM_CH-1:0] w_first_hi;
    logic [NUM_CH-1:0] w_first_all;
    logic [NUM_CH-1:0] w_pick;

    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    // Thermometer mask selecting channels at or above the pointer.
    always_comb begin
        w_mask = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            w_mask[k] = (32'(k) >= 32'(i_ptr));
        end
    end

    assign w_req_hi    = i_req & w_mask;
    assign w_first_hi  = w_req_hi & (~w_req_hi + ONE);
    assign w_first_all = i_req & (~i_req + ONE);

    // Pick the winner per mode and gate it with the enable.
    always_comb begin
        w_pick = {NUM_CH{1'b0}};
        o_gnt  = {NUM_CH{1'b0}};
        if ((MODE == MODE_RR) && (|w_req_hi)) begin
            w_pick = w_first_hi;
        end else begin
            w_pick = w_first_all;
        end
        if (i_en) begin
            o_gnt = w_pick;
        end else begin
            o_gnt = {NUM_CH{1'b0}};
        end
    end

endmodule

// File: rtl/onehot_arb_mux.sv
// N-channel one-hot arbitrated multiplexer with a registered valid/ready stage.
// NUM_CH must be in 2..64 (limited by onehot_index).
module onehot_arb_mux
    import onehot_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_RR,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic [NUM_CH-1:0]        gnt_o,
    output logic                     y_valid_o,
    output logic [DATA_W-1:0]        y_data_o,
    output logic [CH_W-1:0]          y_ch_o,
    input  logic                     y_ready_i
);

    logic              w_accept;
    logic              w_en;
    logic [NUM_CH-1:0] w_gnt;
    logic [DATA_W-1:0] w_sel_data;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [CH_W-1:0]   w_ptr_next;

    logic [CH_W-1:0]   r_ptr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;

    // Grants are suppressed while reset is held so no word is taken mid-reset.
    assign w_accept = (|req_i) && (!r_valid || y_ready_i);
    assign w_en     = w_accept && reset_n;

    onehot_rr_arb #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_arb (
        .i_en  (w_en),
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // AND-OR selection tree driven by the one-hot grant.
    always_comb begin
        w_sel_data = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            w_sel_data = w_sel_data | (data_i[k*DATA_W +: DATA_W] & {DATA_W{w_gnt[k]}});
        end
    end

    assign w_gnt_idx  = CH_W'(onehot_index(ONEHOT_MAX_W'(w_gnt)));
    assign w_ptr_next = (32'(w_gnt_idx) == 32'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                            : (w_gnt_idx + CH_W'(1));

    // Round-robin pointer moves just past the accepted channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= {CH_W{1'b0}};
        end else if (w_en && (MODE == MODE_RR)) begin
            r_ptr <= w_ptr_next;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Output register: fill on accept, drain on ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
            r_ch    <= {CH_W{1'b0}};
        end else if (w_en) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_ch    <= w_gnt_idx;
        end else if (y_ready_i) begin
            r_valid <= 1'b0;
            r_data  <= r_data;
            r_ch    <= r_ch;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
            r_ch    <= r_ch;
        end
    end

    assign gnt_o     = w_gnt;
    assign y_valid_o = r_valid;
    assign y_data_o  = r_data;
    assign y_ch_o    = r_ch;

endmodule

// File: tb/tb_onehot_arb_mux.sv
// Bench for onehot_arb_mux: round-robin and fixed 4x8 instances share one
// vector table; an 8x16 instance runs a single-requester sequence.
module tb_onehot_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [3:0]   req4;
    logic [31:0]  data4;
    logic         rdy4;
    logic [3:0]   gnt_rr, gnt_fx;
    logic         v_rr, v_fx;
    logic [7:0]   yd_rr, yd_fx;
    logic [1:0]   yc_rr, yc_fx;

    logic [7:0]   req8;
    logic [127:0] data8;
    logic         rdy8;
    logic [7:0]   gnt8;
    logic         v8;
    logic [15:0]  yd8;
    logic [2:0]   yc8;

    onehot_arb_mux #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n), .req_i(req4), .data_i(data4), .gnt_o(gnt_rr),
        .y_valid_o(v_rr), .y_data_o(yd_rr), .y_ch_o(yc_rr), .y_ready_i(rdy4));

    onehot_arb_mux #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u_fx (
        .clk(clk), .reset_n(reset_n), .req_i(req4), .data_i(data4), .gnt_o(gnt_fx),
        .y_valid_o(v_fx), .y_data_o(yd_fx), .y_ch_o(yc_fx), .y_ready_i(rdy4));

    onehot_arb_mux #(.NUM_CH(8), .DATA_W(16), .MODE(1)) u_w8 (
        .clk(clk), .reset_n(reset_n), .req_i(req8), .data_i(data8), .gnt_o(gnt8),
        .y_valid_o(v8), .y_data_o(yd8), .y_ch_o(yc8), .y_ready_i(rdy8));

    onehot_arb_mux_chk #(.NUM_CH(4)) u_chk_rr (.clk(clk), .gnt(gnt_rr));
    onehot_arb_mux_chk #(.NUM_CH(4)) u_chk_fx (.clk(clk), .gnt(gnt_fx));
    onehot_arb_mux_chk #(.NUM_CH(8)) u_chk_w8 (.clk(clk), .gnt(gnt8));

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  g_rr;
        logic [3:0]  g_fx;
    } vec_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    localparam int NV = 23;
    vec_t tbl [NV];
    exp_t q_rr [$];
    exp_t q_fx [$];
    exp_t last_rr, last_fx;
    logic exp_valid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx4(input logic [3:0] g);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) r = k;
        end
        return r;
    endfunction

    task automatic pop_or_fail(input string name, inout exp_t q [$], output exp_t e);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
            e = '0;
        end else begin
            e = q.pop_front();
        end
    endtask

    initial begin
        // {rst_n, req, rdy, data, expected grant RR, expected grant fixed}
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h0, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h1, 4'h1};
        tbl[3]  = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h2, 4'h1};
        tbl[4]  = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h4, 4'h1};
        tbl[5]  = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h8, 4'h1};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h1, 4'h1};
        tbl[7]  = '{1'b1, 4'hE, 1'b1, 32'hA3A2A1A0, 4'h2, 4'h2};
        tbl[8]  = '{1'b1, 4'h4, 1'b1, 32'hA35CA1A0, 4'h4, 4'h4};
        tbl[9]  = '{1'b1, 4'hB, 1'b0, 32'hA35CA1A0, 4'h0, 4'h0};
        tbl[10] = '{1'b1, 4'hB, 1'b0, 32'hA35CA1A0, 4'h0, 4'h0};
        tbl[11] = '{1'b1, 4'hB, 1'b0, 32'hA35CA1A0, 4'h0, 4'h0};
        tbl[12] = '{1'b1, 4'hB, 1'b1, 32'hA35CA1A0, 4'h8, 4'h1};
        tbl[13] = '{1'b1, 4'h4, 1'b1, 32'hA35CA1A0, 4'h4, 4'h4};
        tbl[14] = '{1'b1, 4'h3, 1'b1, 32'hA35CA1A0, 4'h1, 4'h1};
        tbl[15] = '{1'b1, 4'h3, 1'b1, 32'hA35CA1A0, 4'h2, 4'h1};
        tbl[16] = '{1'b1, 4'h0, 1'b1, 32'hA35CA1A0, 4'h0, 4'h0};
        tbl[17] = '{1'b1, 4'h0, 1'b1, 32'hA35CA1A0, 4'h0, 4'h0};
        tbl[18] = '{1'b1, 4'hF, 1'b0, 32'hA3A2A1A0, 4'h4, 4'h1};
        tbl[19] = '{1'b0, 4'hF, 1'b0, 32'hA3A2A1A0, 4'h0, 4'h0};
        tbl[20] = '{1'b1, 4'hF, 1'b1, 32'hA3A2A1A0, 4'h1, 4'h1};
        tbl[21] = '{1'b1, 4'h0, 1'b0, 32'hA3A2A1A0, 4'h0, 4'h0};
        tbl[22] = '{1'b1, 4'h0, 1'b1, 32'hA3A2A1A0, 4'h0, 4'h0};

        reset_n   = 1'b0;
        req4      = 4'h0;
        data4     = 32'h0;
        rdy4      = 1'b1;
        req8      = 8'h00;
        data8     = 128'h0;
        rdy8      = 1'b1;
        exp_valid = 1'b0;
        last_rr   = '0;
        last_fx   = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset_n = tbl[i].rst_n;
            req4    = tbl[i].req;
            rdy4    = tbl[i].rdy;
            data4   = tbl[i].data;
            #1;
            chk($sformatf("gnt_rr[%0d]", i), 32'(gnt_rr), 32'(tbl[i].g_rr));
            chk($sformatf("gnt_fx[%0d]", i), 32'(gnt_fx), 32'(tbl[i].g_fx));
            if (tbl[i].g_rr != 4'h0)
                q_rr.push_back('{ch: 2'(idx4(tbl[i].g_rr)), data: data4[8*idx4(tbl[i].g_rr) +: 8]});
            if (tbl[i].g_fx != 4'h0)
                q_fx.push_back('{ch: 2'(idx4(tbl[i].g_fx)), data: data4[8*idx4(tbl[i].g_fx) +: 8]});

            @(posedge clk);
            #1;
            if (!tbl[i].rst_n) begin
                exp_valid = 1'b0;
                last_rr   = '0;
                last_fx   = '0;
            end else begin
                if (tbl[i].g_rr != 4'h0) begin
                    exp_valid = 1'b1;
                end else begin
                    exp_valid = exp_valid && !tbl[i].rdy;
                end
                if (tbl[i].g_rr != 4'h0) pop_or_fail($sformatf("sb_rr[%0d]", i), q_rr, last_rr);
                if (tbl[i].g_fx != 4'h0) pop_or_fail($sformatf("sb_fx[%0d]", i), q_fx, last_fx);
            end
            chk($sformatf("valid_rr[%0d]", i), 32'(v_rr), 32'(exp_valid));
            chk($sformatf("valid_fx[%0d]", i), 32'(v_fx), 32'(exp_valid));
            chk($sformatf("ch_rr[%0d]", i), 32'(yc_rr), 32'(last_rr.ch));
            chk($sformatf("data_rr[%0d]", i), 32'(yd_rr), 32'(last_rr.data));
            chk($sformatf("ch_fx[%0d]", i), 32'(yc_fx), 32'(last_fx.ch));
            chk($sformatf("data_fx[%0d]", i), 32'(yd_fx), 32'(last_fx.data));
            chk($sformatf("valid_w8_idle[%0d]", i), 32'(v8), 32'd0);
        end

        // Single requester on the top channel of the 8-channel instance.
        @(negedge clk);
        for (int k = 0; k < 8; k++) data8[16*k +: 16] = 16'(k) * 16'h1111;
        data8[127:112] = 16'hBEEF;
        req8 = 8'h80;
        #1;
        chk("gnt_w8_req", 32'(gnt8), 32'h80);
        @(posedge clk);
        #1;
        chk("valid_w8_load", 32'(v8), 32'd1);
        chk("ch_w8_load", 32'(yc8), 32'd7);
        chk("data_w8_load", 32'(yd8), 32'hBEEF);
        @(negedge clk);
        req8 = 8'h00;
        #1;
        chk("gnt_w8_drop", 32'(gnt8), 32'h0);
        @(posedge clk);
        #1;
        chk("valid_w8_drain", 32'(v8), 32'd0);
        chk("ch_w8_hold", 32'(yc8), 32'd7);
        chk("data_w8_hold", 32'(yd8), 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
